alu_resp_checker: RTL

ALU_RESP_CHECKER -- requirements
Module: alu_resp_checker

---
 rtl/alu_resp_checker.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_resp_checker.sv
// Scoreboard for a 3-bit-opcode ALU: registers each stimulus/response pair, compares it
// against a golden result one cycle later, counts outcomes and logs mismatches (ALU_CHK_LOG_EN).
module alu_resp_checker #(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_cin,
  input  logic [2:0]         in_s,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_cout,
  input  logic               clr,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic               chk_valid,
  output logic               chk_fail,
  output logic               log_valid,
  input  logic               log_rd,
  output logic [3*WIDTH+4:0] log_data
);

  localparam int REC_W = 3*WIDTH + 5;

  typedef enum logic {ST_OK, ST_ERR_HOLD} state_e;

  logic             r_valid;
  logic [WIDTH-1:0] r_a, r_b, r_out;
  logic             r_cin, r_cout;
  logic [2:0]       r_s;
  logic [WIDTH:0]   w_exp;
  logic             w_mismatch, w_cmp, w_pass, w_fail;
  state_e           r_state, w_state_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_cin   <= 1'b0;
      r_cout  <= 1'b0;
      r_s     <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_out  <= alu_out;
        r_cin  <= in_cin;
        r_cout <= alu_cout;
        r_s    <= in_s;
      end
    end
  end

  // Golden {cout, result}; subtraction's top bit is the borrow of the widened difference.
  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    w_exp = '0;
    case (r_s)
      3'b000:  w_exp = {1'b0, r_a} + {1'b0, r_b} + (WIDTH+1)'(r_cin);
      3'b001:  w_exp = {1'b0, r_a} - {1'b0, r_b} - (WIDTH+1)'(r_cin);
      3'b010:  w_exp = {1'b0, r_a & r_b};
      3'b011:  w_exp = {1'b0, r_a | r_b};
      3'b100:  w_exp = {1'b0, r_a ^ r_b};
      3'b101:  w_exp = {1'b0, ~r_a};
      3'b110:  w_exp = {r_a, 1'b0};
      3'b111:  w_exp = {r_a[0], 1'b0, r_a[WIDTH-1:1]};
      default: w_exp = '0;
    endcase
  end

  // A clear in the same cycle discards the compare entirely.
  assign w_mismatch = (w_exp != {r_cout, r_out});
  assign w_cmp      = r_valid & ~clr;
  assign w_pass     = w_cmp & ~w_mismatch;
  assign w_fail     = w_cmp & w_mismatch;
  assign chk_valid  = w_cmp;
  assign chk_fail   = w_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      if (w_pass && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (w_fail && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
    end
  end

  // Error-hold state is deliberately untouched by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_OK;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OK:       if (w_fail) w_state_nxt = ST_ERR_HOLD;
      ST_ERR_HOLD: if (w_pass) w_state_nxt = ST_OK;
      default:     w_state_nxt = ST_OK;
    endcase
  end

`ifdef ALU_CHK_LOG_EN
  localparam int AW = $clog2(LOG_DEPTH);

  logic [REC_W-1:0] r_mem [LOG_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_last_ptr;
  logic [AW:0]      r_count;
  logic             w_empty, w_full, w_pop, w_push_ok, w_drop;
  logic [REC_W-1:0] w_rec;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (AW+1)'(LOG_DEPTH));
  assign w_pop      = log_rd & ~w_empty & ~clr;
  assign w_push_ok  = w_fail & (~w_full | w_pop);
  assign w_drop     = w_fail & w_full & ~w_pop;
  assign w_last_ptr = r_wr_ptr - AW'(1);
  assign w_rec      = {r_s, r_a, r_b, r_out, r_cout, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push_ok) r_count <= r_count - (AW+1)'(1);
    end
  end

  // NOTE: log storage has no reset; entries are only observable through the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push_ok)   r_mem[r_wr_ptr]      <= w_rec;
    else if (w_drop) r_mem[w_last_ptr][0] <= 1'b1;
  end

  assign log_valid = ~w_empty;
  assign log_data  = w_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic w_unused_rd;
  assign w_unused_rd = log_rd;
  assign log_valid   = 1'b0;
  assign log_data    = '0;
`endif

endmodule
